// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@72 raster timing constants for the timing generator,
// the parallax renderer and the bench.
package vga_pkg;

  localparam int unsigned POS_W = 10;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 24;
  localparam int unsigned VGA_H_SYNC    = 40;
  localparam int unsigned VGA_H_BACK    = 128;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 9;
  localparam int unsigned VGA_V_SYNC    = 3;
  localparam int unsigned VGA_V_BACK    = 28;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam bit VGA_H_SYNC_POL = 1'b0;
  localparam bit VGA_V_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Position, wrap flag and sync are flops decoded
// from the next position; active_next is the next-cycle visible flag for the parent to register.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned FRONT    = VGA_H_FRONT,
  parameter int unsigned SYNC     = VGA_H_SYNC,
  parameter int unsigned BACK     = VGA_H_BACK,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             sync,
  output logic             active_next
);

  localparam int unsigned      TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] SYNC_FIRST = POS_W'(VISIBLE + FRONT);
  localparam logic [POS_W-1:0] SYNC_LAST  = POS_W'(VISIBLE + FRONT + SYNC - 1);
  localparam logic [POS_W-1:0] VIS_END    = POS_W'(VISIBLE);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;
  logic             sync_q, sync_d;

  // wrap_q flags "currently at the last position", so it doubles as the
  // enable for the next axis on the very edge this axis returns to zero.
  always_comb begin
    pos_d = pos_q;
    if (enable) begin
      pos_d = wrap_q ? '0 : pos_q + POS_W'(1);
    end
    wrap_d      = (pos_d == LAST);
    sync_d      = ((pos_d >= SYNC_FIRST) && (pos_d <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    active_next = (pos_d < VIS_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q  <= LAST;
      wrap_q <= 1'b1;
      sync_q <= ~SYNC_POL;
    end else begin
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      sync_q <= sync_d;
    end
  end

  assign pos  = pos_q;
  assign wrap = wrap_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@72 raster generator, all outputs registered and position-aligned.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/display_on by SYNC_DELAY clocks.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter bit          H_SYNC_POL = VGA_H_SYNC_POL,
  parameter bit          V_SYNC_POL = VGA_V_SYNC_POL,
  parameter int unsigned FRAME_W    = 8,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  if ((SYNC_DELAY == 0) || (SYNC_DELAY > 4)) begin : g_bad_sync_delay
    $error("vga_timing: SYNC_DELAY must be in 1..4");
  end

  logic h_wrap, v_wrap;
  logic h_sync, v_sync;
  logic h_active_next, v_active_next;

  vga_axis_counter #(
    .VISIBLE  (H_VISIBLE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (H_SYNC_POL)
  ) u_h_axis (
    .clk         (clk),
    .reset       (reset),
    .enable      (1'b1),
    .pos         (hpos),
    .wrap        (h_wrap),
    .sync        (h_sync),
    .active_next (h_active_next)
  );

  vga_axis_counter #(
    .VISIBLE  (V_VISIBLE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (V_SYNC_POL)
  ) u_v_axis (
    .clk         (clk),
    .reset       (reset),
    .enable      (h_wrap),
    .pos         (vpos),
    .wrap        (v_wrap),
    .sync        (v_sync),
    .active_next (v_active_next)
  );

  logic               display_on_q, display_on_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // A set wrap flag means the next edge lands on column 0 (and row 0 if both are set).
  always_comb begin
    display_on_d  = h_active_next && v_active_next;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    frame_cnt_d   = frame_start_d ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '1;
    end else begin
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [SYNC_DELAY-1:0] de_pipe_q, de_pipe_d;

  // Stage 0 takes the aligned flops, so the tap lags hpos/vpos by SYNC_DELAY clocks.
  always_comb begin
    hs_pipe_d[0] = h_sync;
    vs_pipe_d[0] = v_sync;
    de_pipe_d[0] = display_on_q;
    for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
      de_pipe_d[i] = de_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_pipe_q <= {SYNC_DELAY{~H_SYNC_POL}};
      vs_pipe_q <= {SYNC_DELAY{~V_SYNC_POL}};
      de_pipe_q <= '0;
    end else begin
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_pipe_q <= de_pipe_d;
    end
  end

  assign hsync      = hs_pipe_q[SYNC_DELAY-1];
  assign vsync      = vs_pipe_q[SYNC_DELAY-1];
  assign display_on = de_pipe_q[SYNC_DELAY-1];
`else
  assign hsync      = h_sync;
  assign vsync      = v_sync;
  assign display_on = display_on_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks on the 640x480 generator plus a tiny-raster
// instance for frame-level behaviour, with a position-based reference per cycle.
module tb_vga_timing;

`ifdef VGA_SYNC_DELAY_EN
  localparam int unsigned DLY = 2;
`else
  localparam int unsigned DLY = 0;
`endif

  // Index 0: full 640x480 timing, index 1: 16x12 raster.
  localparam int unsigned P_HV [2] = '{640, 8};
  localparam int unsigned P_HF [2] = '{24, 2};
  localparam int unsigned P_HS [2] = '{40, 3};
  localparam int unsigned P_HB [2] = '{128, 3};
  localparam int unsigned P_VV [2] = '{480, 6};
  localparam int unsigned P_VF [2] = '{9, 1};
  localparam int unsigned P_VS [2] = '{3, 2};
  localparam int unsigned P_VB [2] = '{28, 3};

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       a_hsync, a_vsync, a_de, a_ls, a_fs;
  logic [9:0] a_hpos, a_vpos;
  logic [7:0] a_fc;
  logic       b_hsync, b_vsync, b_de, b_ls, b_fs;
  logic [9:0] b_hpos, b_vpos;
  logic [7:0] b_fc;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  int unsigned mh [2];
  int unsigned mv [2];
  logic [7:0]  mf [2];
  logic [2:0]  hist [2][4];

  always #5 clk = ~clk;

  vga_timing u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .hsync       (a_hsync),
    .vsync       (a_vsync),
    .display_on  (a_de),
    .hpos        (a_hpos),
    .vpos        (a_vpos),
    .line_start  (a_ls),
    .frame_start (a_fs),
    .frame_cnt   (a_fc)
  );

  vga_timing #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_VISIBLE (6),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (3)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .hsync       (b_hsync),
    .vsync       (b_vsync),
    .display_on  (b_de),
    .hpos        (b_hpos),
    .vpos        (b_vpos),
    .line_start  (b_ls),
    .frame_start (b_fs),
    .frame_cnt   (b_fc)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ht(input int d);
    return P_HV[d] + P_HF[d] + P_HS[d] + P_HB[d];
  endfunction

  function automatic int unsigned vt(input int d);
    return P_VV[d] + P_VF[d] + P_VS[d] + P_VB[d];
  endfunction

  // {hsync, vsync, display_on} for an undelayed beam at (h, v), active-low syncs.
  function automatic logic [2:0] undel(input int d, input int unsigned h, input int unsigned v);
    logic hs, vs, de;
    hs = !((h >= P_HV[d] + P_HF[d]) && (h <= P_HV[d] + P_HF[d] + P_HS[d] - 1));
    vs = !((v >= P_VV[d] + P_VF[d]) && (v <= P_VV[d] + P_VF[d] + P_VS[d] - 1));
    de = (h < P_HV[d]) && (v < P_VV[d]);
    return {hs, vs, de};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mh[d] = ht(d) - 1;
      mv[d] = vt(d) - 1;
      mf[d] = 8'hFF;
      for (int k = 0; k < 4; k++) hist[d][k] = 3'b110;
    end
  endtask

  task automatic model_advance();
    for (int d = 0; d < 2; d++) begin
      for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0] = undel(d, mh[d], mv[d]);
      if (mh[d] == ht(d) - 1) begin
        mh[d] = 0;
        if (mv[d] == vt(d) - 1) begin
          mv[d] = 0;
          mf[d] = mf[d] + 8'd1;
        end else begin
          mv[d] = mv[d] + 1;
        end
      end else begin
        mh[d] = mh[d] + 1;
      end
    end
  endtask

  function automatic logic [39:0] expected(input int d);
    logic [2:0] u;
    int k;
    k = (DLY == 0) ? 0 : int'(DLY) - 1;
    u = (DLY == 0) ? undel(d, mh[d], mv[d]) : hist[d][k];
    return {7'b0, u, (mh[d] == 0), (mh[d] == 0) && (mv[d] == 0), mf[d], 10'(mv[d]), 10'(mh[d])};
  endfunction

  function automatic logic [39:0] got_a();
    return {7'b0, a_hsync, a_vsync, a_de, a_ls, a_fs, a_fc, a_vpos, a_hpos};
  endfunction

  function automatic logic [39:0] got_b();
    return {7'b0, b_hsync, b_vsync, b_de, b_ls, b_fs, b_fc, b_vpos, b_hpos};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_advance();
    check("a_cycle", got_a(), expected(0));
    check("b_cycle", got_b(), expected(1));
  endtask

  task automatic run_to(input int unsigned h, input int unsigned v, input string tag);
    int unsigned n;
    logic found;
    found = 1'b0;
    for (n = 0; n < 20000; n++) begin
      if ((a_hpos == 10'(h)) && (a_vpos == 10'(v))) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, 40'(found), 40'd1);
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, de_cnt, de_fall, ls_cnt;
    int bvs_cnt, bvs_first, nfs;
    int fs_t [3];
    int fs_c [3];
    logic prev_de;

    model_reset();
    reset = 1'b1;
    repeat (5) step();

    check("rst_hpos",  40'(a_hpos), 40'd831);
    check("rst_vpos",  40'(a_vpos), 40'd519);
    check("rst_hsync", 40'(a_hsync), 40'd1);
    check("rst_vsync", 40'(a_vsync), 40'd1);
    check("rst_de",    40'(a_de), 40'd0);
    check("rst_strb",  40'({a_ls, a_fs}), 40'd0);
    check("rst_fcnt",  40'(a_fc), 40'hFF);

    #4 reset = 1'b0;

    hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; de_fall = -1; ls_cnt = 0;
    bvs_cnt = 0; bvs_first = -1; nfs = 0; prev_de = 1'b0;
    fs_t = '{-1, -1, -1};
    fs_c = '{-1, -1, -1};

    for (int i = 0; i < 832; i++) begin
      step();
      if (i == 0) begin
        check("first_pos",  40'({a_vpos, a_hpos}), 40'd0);
        check("first_strb", 40'({a_ls, a_fs}), 40'b11);
        check("first_fcnt", 40'(a_fc), 40'd0);
        check("first_de",   40'(a_de), (DLY == 0) ? 40'd1 : 40'd0);
      end
      if (!a_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (a_de) de_cnt++;
      if (prev_de && !a_de && (de_fall < 0)) de_fall = i;
      prev_de = a_de;
      if (a_ls) ls_cnt++;
      if ((i < 192) && !b_vsync) begin
        bvs_cnt++;
        if (bvs_first < 0) bvs_first = i;
      end
      if (b_fs && (nfs < 3)) begin
        fs_t[nfs] = i;
        fs_c[nfs] = int'(b_fc);
        nfs++;
      end
      if (i == 191) check("b_last_pos", 40'({b_vpos, b_hpos}), 40'({10'd11, 10'd15}));
      if (i == 192) check("b_wrap_pos", 40'({b_vpos, b_hpos, b_fs}), 40'({10'd0, 10'd0, 1'b1}));
    end

    check("hs_low_cnt", 40'(hs_cnt), 40'd40);
    check("hs_first",   40'(hs_first), 40'(664 + DLY));
    check("hs_last",    40'(hs_last), 40'(703 + DLY));
    check("de_cnt",     40'(de_cnt), 40'd640);
    check("de_fall",    40'(de_fall), 40'(640 + DLY));
    check("ls_in_line", 40'(ls_cnt), 40'd1);
    check("b_vs_cnt",   40'(bvs_cnt), 40'd32);
    check("b_vs_first", 40'(bvs_first), 40'(112 + DLY));
    check("b_fs_num",   40'(nfs), 40'd3);
    check("b_fs_t1",    40'(fs_t[1]), 40'd192);
    check("b_fs_t2",    40'(fs_t[2]), 40'd384);
    check("b_fs_c0",    40'(fs_c[0]), 40'd0);
    check("b_fs_c1",    40'(fs_c[1]), 40'd1);
    check("b_fs_c2",    40'(fs_c[2]), 40'd2);

    step();
    check("line_period", 40'({a_ls, a_fs, a_vpos, a_hpos}), 40'({1'b1, 1'b0, 10'd1, 10'd0}));

    run_to(831, 10, "reach_831_10");
    step();
    check("line_wrap", 40'({a_vpos, a_hpos, a_ls, a_fs}), 40'({10'd11, 10'd0, 1'b1, 1'b0}));

    run_to(300, 12, "reach_300_12");
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_a", got_a(), 40'({7'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 10'd519, 10'd831}));
    check("async_rst_b", got_b(), 40'({7'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 10'd11, 10'd15}));
    repeat (2) step();
    #4 reset = 1'b0;
    step();
    check("restart_a", 40'({a_vpos, a_hpos, a_ls, a_fs, a_fc}), 40'({10'd0, 10'd0, 1'b1, 1'b1, 8'd0}));
    check("restart_b_fcnt", 40'(b_fc), 40'd0);
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
